// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state encodings, RFLAGS bit positions and flag helpers for the execute stage.
package alu_pkg;
   typedef enum logic [3:0] {NOP, ADD, SUB, CMP, AND, OR, XOR, MOV, JCC, JMP, MUL} alu_op_t;
   typedef enum logic {S_IDLE, S_MUL} alu_state_t;
   localparam int RF_CF = 0;
   localparam int RF_PF = 2;
   localparam int RF_ZF = 6;
   localparam int RF_SF = 7;
   localparam int RF_OF = 11;
   localparam logic [63:0] RFLAGS_RESET = 64'h2;
   // x86 tttn: cond[3:1] picks the predicate, cond[0] negates it
   function automatic logic cond_true(input logic [3:0] cond, input logic [63:0] rf);
      logic c;
      logic lt;
      lt = rf[RF_SF] ^ rf[RF_OF];
      c  = 1'b0;
      case (cond[3:1])
         3'd0: c = rf[RF_OF];
         3'd1: c = rf[RF_CF];
         3'd2: c = rf[RF_ZF];
         3'd3: c = rf[RF_CF] | rf[RF_ZF];
         3'd4: c = rf[RF_SF];
         3'd5: c = rf[RF_PF];
         3'd6: c = lt;
         3'd7: c = rf[RF_ZF] | lt;
         default: c = 1'b0;
      endcase
      return c ^ cond[0];
   endfunction
   function automatic logic [63:0] upd_flags(input logic [63:0] rf, input logic cf, input logic pf,
                                             input logic zf, input logic sf, input logic of);
      logic [63:0] r;
      r        = rf;
      r[1]     = 1'b1;
      r[RF_CF] = cf;
      r[RF_PF] = pf;
      r[RF_ZF] = zf;
      r[RF_SF] = sf;
      r[RF_OF] = of;
      return r;
   endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per enabled cycle.
module alu_mul_iter #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // product is the accumulator after the current step, so the last step can be consumed directly
   always_comb begin
      product  = acc_q + (mplier_q[0] ? mcand_q : '0);
      done     = cnt_q == CW'(WIDTH - 1);
      acc_d    = start ? '0 : en ? product : acc_q;
      mcand_d  = start ? {{WIDTH{1'b0}}, a} : en ? mcand_q << 1 : mcand_q;
      mplier_d = start ? b : en ? mplier_q >> 1 : mplier_q;
      cnt_d    = start ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: execute stage with integer ALU, architectural RFLAGS, Jcc/JMP resolution and iterative MUL,
// feeding a one-entry valid/ready output register.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter bit MUL_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  alu_op_t            in_op,
   input  logic [3:0]         in_cond,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [63:0]        in_next_rip,
   input  logic [63:0]        in_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic               out_wr_reg,
   output logic               out_illegal,
   output logic               branch_taken,
   output logic [63:0]        branch_rip,
   output logic [63:0]        rflags
);
   alu_state_t         state_q, state_d;
   logic               out_valid_q, out_valid_d, out_wr_reg_q, out_wr_reg_d;
   logic               out_illegal_q, out_illegal_d, branch_taken_q, branch_taken_d;
   logic [2*WIDTH-1:0] out_result_q, out_result_d, mul_prod;
   logic [63:0]        branch_rip_q, branch_rip_d, rflags_q, rflags_d, mul_rip_q, mul_rip_d;
   logic               slot_free, accept, go_mul, mul_done, mul_en, mul_fire;
   logic               wr, ill, tk, fl, cf, of;
   logic [WIDTH-1:0]   res;
   logic [WIDTH:0]     sum, dif;
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = (state_q == S_IDLE) && slot_free;
   assign accept    = in_valid && in_ready;
   assign mul_fire  = (state_q == S_MUL) && mul_done && slot_free;
   assign mul_en    = (state_q == S_MUL) && (!mul_done || slot_free);
   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && go_mul),
      .en      (mul_en),
      .a       (in_a),
      .b       (in_b),
      .done    (mul_done),
      .product (mul_prod)
   );
   always_comb begin
      sum    = {1'b0, in_a} + {1'b0, in_b};
      dif    = {1'b0, in_a} - {1'b0, in_b};
      res    = '0;
      wr     = 1'b1;
      ill    = 1'b0;
      tk     = 1'b0;
      fl     = 1'b0;
      cf     = 1'b0;
      of     = 1'b0;
      go_mul = 1'b0;
      case (in_op)
         NOP: wr = 1'b0;
         ADD: begin
            res = sum[WIDTH-1:0];
            cf  = sum[WIDTH];
            of  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            fl  = 1'b1;
         end
         SUB, CMP: begin
            res = dif[WIDTH-1:0];
            cf  = dif[WIDTH];
            of  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (dif[WIDTH-1] != in_a[WIDTH-1]);
            fl  = 1'b1;
            wr  = in_op == SUB;
         end
         AND: begin res = in_a & in_b; fl = 1'b1; end
         OR:  begin res = in_a | in_b; fl = 1'b1; end
         XOR: begin res = in_a ^ in_b; fl = 1'b1; end
         MOV: res = in_b;
         JCC: begin wr = 1'b0; tk = cond_true(in_cond, rflags_q); end
         JMP: begin wr = 1'b0; tk = 1'b1; end
         MUL: begin go_mul = MUL_EN; ill = !MUL_EN; wr = MUL_EN; end
         default: begin ill = 1'b1; wr = 1'b0; end
      endcase
   end
   always_comb begin
      state_d = state_q;
      if (accept && go_mul) state_d = S_MUL;
      else if (mul_fire) state_d = S_IDLE;
   end
   always_comb begin
      out_valid_d    = out_valid_q && !out_ready;
      out_result_d   = out_result_q;
      out_wr_reg_d   = out_wr_reg_q;
      out_illegal_d  = out_illegal_q;
      branch_taken_d = branch_taken_q;
      branch_rip_d   = branch_rip_q;
      rflags_d       = rflags_q;
      mul_rip_d      = accept ? in_next_rip : mul_rip_q;
      if (accept && !go_mul) begin
         out_valid_d    = 1'b1;
         out_result_d   = {{WIDTH{1'b0}}, res};
         out_wr_reg_d   = wr;
         out_illegal_d  = ill;
         branch_taken_d = tk;
         branch_rip_d   = tk ? in_target : in_next_rip;
         rflags_d       = fl ? upd_flags(rflags_q, cf, ~^res[7:0], res == '0, res[WIDTH-1], of) : rflags_q;
      end else if (mul_fire) begin
         out_valid_d    = 1'b1;
         out_result_d   = mul_prod;
         out_wr_reg_d   = 1'b1;
         out_illegal_d  = 1'b0;
         branch_taken_d = 1'b0;
         branch_rip_d   = mul_rip_q;
         rflags_d       = upd_flags(rflags_q, |mul_prod[2*WIDTH-1:WIDTH], ~^mul_prod[7:0],
                                    mul_prod[WIDTH-1:0] == '0, mul_prod[WIDTH-1],
                                    |mul_prod[2*WIDTH-1:WIDTH]);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else state_q <= state_d;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q    <= 1'b0;
         out_result_q   <= '0;
         out_wr_reg_q   <= 1'b0;
         out_illegal_q  <= 1'b0;
         branch_taken_q <= 1'b0;
         branch_rip_q   <= '0;
         rflags_q       <= RFLAGS_RESET;
         mul_rip_q      <= '0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_result_q   <= out_result_d;
         out_wr_reg_q   <= out_wr_reg_d;
         out_illegal_q  <= out_illegal_d;
         branch_taken_q <= branch_taken_d;
         branch_rip_q   <= branch_rip_d;
         rflags_q       <= rflags_d;
         mul_rip_q      <= mul_rip_d;
      end
   end
   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_wr_reg   = out_wr_reg_q;
   assign out_illegal  = out_illegal_q;
   assign branch_taken = branch_taken_q;
   assign branch_rip   = branch_rip_q;
   assign rflags       = rflags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=64.
module tb_alu_pipe;
   import alu_pkg::*;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   alu_op_t       in_op = NOP;
   logic [3:0]    in_cond = 4'd0;
   logic [63:0]   in_a = '0, in_b = '0, in_next_rip = '0, in_target = '0;
   logic          out_valid, out_ready = 1'b1;
   logic [127:0]  out_result;
   logic          out_wr_reg, out_illegal, branch_taken;
   logic [63:0]   branch_rip, rflags;
   int            checks = 0;
   int            errors = 0;
   always #5 clk = ~clk;
   alu_pipe #(.WIDTH(64), .MUL_EN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_cond      (in_cond),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_next_rip  (in_next_rip),
      .in_target    (in_target),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_wr_reg   (out_wr_reg),
      .out_illegal  (out_illegal),
      .branch_taken (branch_taken),
      .branch_rip   (branch_rip),
      .rflags       (rflags)
   );
   // presents one op for exactly one edge; caller guarantees in_ready
   task automatic issue(input alu_op_t op, input logic [3:0] cond, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] nrip, input logic [63:0] tgt);
      in_op = op; in_cond = cond; in_a = a; in_b = b; in_next_rip = nrip; in_target = tgt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({out_valid, out_wr_reg, out_illegal, branch_taken} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, out_wr_reg, out_illegal, branch_taken});
      end
      checks++;
      if (out_result !== 128'd0 || branch_rip !== 64'd0) begin
         errors++; $display("FAIL reset_data: got result %h rip %h expected 0 0", out_result, branch_rip);
      end
      checks++;
      if (rflags !== 64'h2 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_flags: got rflags %h in_ready %b expected 2 1", rflags, in_ready);
      end
   endtask
   task automatic test_add;
      issue(ADD, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'h0);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 128'd0 || out_wr_reg !== 1'b1) begin
         errors++; $display("FAIL add_wrap: got v=%b res=%h wr=%b expected 1 0 1", out_valid, out_result, out_wr_reg);
      end
      checks++;
      if (rflags !== 64'h47) begin
         errors++; $display("FAIL add_wrap_flags: got %h expected 47", rflags);
      end
      issue(ADD, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'h0);
      checks++;
      if (out_result !== 128'h8000_0000_0000_0000) begin
         errors++; $display("FAIL add_ovf: got %h expected 8000000000000000", out_result);
      end
      checks++;
      if (rflags !== 64'h886) begin
         errors++; $display("FAIL add_ovf_flags: got %h expected 886", rflags);
      end
   endtask
   task automatic test_cmp_jcc;
      issue(CMP, 4'd0, 64'd3, 64'd5, 64'h1000, 64'h0);
      checks++;
      if (out_wr_reg !== 1'b0 || out_result !== 128'hFFFF_FFFF_FFFF_FFFE) begin
         errors++; $display("FAIL cmp_out: got wr=%b res=%h expected 0 fffffffffffffffe", out_wr_reg, out_result);
      end
      checks++;
      if (rflags !== 64'h83) begin
         errors++; $display("FAIL cmp_flags: got %h expected 83", rflags);
      end
      issue(JCC, 4'd2, 64'd0, 64'd0, 64'h1004, 64'h4000);
      checks++;
      if (branch_taken !== 1'b1 || branch_rip !== 64'h4000 || out_wr_reg !== 1'b0) begin
         errors++; $display("FAIL jcc_b: got tk=%b rip=%h wr=%b expected 1 4000 0", branch_taken, branch_rip, out_wr_reg);
      end
      issue(JCC, 4'd3, 64'd0, 64'd0, 64'h1008, 64'h4000);
      checks++;
      if (branch_taken !== 1'b0 || branch_rip !== 64'h1008 || rflags !== 64'h83) begin
         errors++; $display("FAIL jcc_ae: got tk=%b rip=%h fl=%h expected 0 1008 83", branch_taken, branch_rip, rflags);
      end
      issue(JMP, 4'd0, 64'd0, 64'd0, 64'h100C, 64'h8000);
      checks++;
      if (branch_taken !== 1'b1 || branch_rip !== 64'h8000) begin
         errors++; $display("FAIL jmp: got tk=%b rip=%h expected 1 8000", branch_taken, branch_rip);
      end
   endtask
   task automatic test_mul;
      int bad = 0;
      issue(MUL, 4'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h2000, 64'h0);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      for (int i = 1; i < 64; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL mul_busy: got %0d busy cycles with valid/ready set expected 0", bad);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 128'h1_0000_0000_0000_0000 || out_wr_reg !== 1'b1) begin
         errors++; $display("FAIL mul_result: got v=%b res=%h expected 1 10000000000000000", out_valid, out_result);
      end
      checks++;
      if (rflags !== 64'h847 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mul_flags: got fl=%h rdy=%b expected 847 1", rflags, in_ready);
      end
   endtask
   task automatic test_back_to_back;
      int bad = 0;
      issue(XOR, 4'd0, 64'd5, 64'd3, 64'h0, 64'h0);
      checks++;
      if (out_result !== 128'd6 || rflags !== 64'h6) begin
         errors++; $display("FAIL xor: got res=%h fl=%h expected 6 6", out_result, rflags);
      end
      out_ready = 1'b0;
      in_op = ADD; in_a = 64'd1; in_b = 64'd1; in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_result !== 128'd6 || in_ready !== 1'b0 || rflags !== 64'h6) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL stall_hold: got %0d cycles with entry disturbed expected 0", bad);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 128'd2) begin
         errors++; $display("FAIL release_add: got v=%b res=%h expected 1 2", out_valid, out_result);
      end
      in_op = AND; in_a = 64'hF; in_b = 64'h3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 128'd3 || rflags !== 64'h6) begin
         errors++; $display("FAIL b2b_and: got v=%b res=%h fl=%h expected 1 3 6", out_valid, out_result, rflags);
      end
   endtask
   task automatic test_reset_mid_mul;
      int bad = 0;
      issue(MUL, 4'd0, 64'd3, 64'd7, 64'h0, 64'h0);
      repeat (29) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || rflags !== 64'h2 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mul_abort: got v=%b fl=%h rdy=%b expected 0 2 1", out_valid, rflags, in_ready);
      end
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL mul_abort_quiet: got %0d stray valid cycles expected 0", bad);
      end
   endtask
   task automatic test_illegal;
      issue(alu_op_t'(4'd13), 4'd0, 64'd9, 64'd9, 64'h0, 64'h0);
      checks++;
      if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_wr_reg !== 1'b0 || out_result !== 128'd0) begin
         errors++; $display("FAIL illegal: got v=%b ill=%b wr=%b res=%h expected 1 1 0 0",
                            out_valid, out_illegal, out_wr_reg, out_result);
      end
      checks++;
      if (rflags !== 64'h2) begin
         errors++; $display("FAIL illegal_flags: got %h expected 2", rflags);
      end
   endtask
   initial begin
      test_reset;
      test_add;
      test_cmp_jcc;
      test_mul;
      test_back_to_back;
      test_reset_mid_mul;
      test_illegal;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
